// File: rtl/ifu_fetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch queue.
package ifu_pkg;

  localparam int XLEN       = 64;
  localparam int ILEN       = 32;
  localparam int INST_BYTES = 4;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
    logic            err;
  } fetch_entry_t;

  function automatic logic pc_misaligned(input logic [1:0] pc_lo);
    return (pc_lo != 2'b00);
  endfunction

endpackage

// File: rtl/ifu_fetch_queue_if.sv
// Instruction-memory request/response and decode-side handshake bundle.
interface ifu_fetch_queue_if
  import ifu_pkg::*;
#(
  parameter int XLEN = ifu_pkg::XLEN,
  parameter int ILEN = ifu_pkg::ILEN
);

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [ILEN-1:0] imem_resp_data;
  logic            imem_resp_err;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst_pc;
  logic [ILEN-1:0] inst_data;
  logic            inst_err;

  // master is the fetch queue, slave is the memory plus decode side
  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst_pc, inst_data, inst_err,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst_pc, inst_data, inst_err,
    output imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err, inst_ready
  );

endinterface

// File: rtl/ifu_fetch_queue_chk.sv
// Protocol checks for the fetch queue's memory and queue interfaces.
module ifu_fetch_queue_chk #(
  parameter int OW = 2
) (
  input logic          clk,
  input logic          reset,
  input logic          resp_valid,
  input logic [OW-1:0] outst,
  input logic          push,
  input logic          full,
  input logic          pop,
  input logic          flush
);

  a_resp_has_outst: assert property (@(posedge clk) disable iff (!reset)
    resp_valid |-> (outst != '0));

  a_no_push_full: assert property (@(posedge clk) disable iff (!reset)
    (push && full) |-> (pop || flush));

endmodule

// File: rtl/ifu_inst_fifo.sv
// Generic wrap-pointer FIFO with flush; head is read from storage, so a push
// becomes visible one cycle later.
module ifu_inst_fifo
  import ifu_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  output entry_t        head,
  output logic          head_valid,
  output logic          full,
  output logic [CW-1:0] count
);

  localparam int          PW      = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_W = CW'(DEPTH);

  entry_t          mem_r [DEPTH];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic            do_push_s;
  logic            do_pop_s;

  // qualify pop by occupancy and push by space, allowing push+pop at full
  always_comb begin
    do_pop_s  = pop && (count_r != '0);
    do_push_s = push && ((count_r != DEPTH_W) || do_pop_s);
  end

  // storage, pointers and occupancy; flush may coincide with a single push
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      rd_ptr_r <= '0;
      if (push) begin
        mem_r[0] <= push_data;
        wr_ptr_r <= PW'(1);
        count_r  <= CW'(1);
      end else begin
        wr_ptr_r <= '0;
        count_r  <= '0;
      end
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
    end
  end

  assign head       = mem_r[rd_ptr_r];
  assign head_valid = (count_r != '0);
  assign full       = (count_r == DEPTH_W);
  assign count      = count_r;

endmodule

// File: rtl/ifu_fetch_queue.sv
// Instruction-fetch front end: credit-limited in-order issue, response
// tracking with stale-response drop, and a decode-facing instruction queue.
module ifu_fetch_queue
  import ifu_pkg::*;
#(
  parameter int              XLEN      = ifu_pkg::XLEN,
  parameter int              ILEN      = ifu_pkg::ILEN,
  parameter int              DEPTH     = 4,
  parameter int              MAX_OUTST = 2,
  parameter logic [XLEN-1:0] RESET_PC  = 64'h8000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  ifu_fetch_queue_if.master bus,
  output logic            busy
);

  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = ((OW > CW) ? OW : CW) + 1;
  localparam logic [OW-1:0]   OUTST_MAX = OW'(MAX_OUTST);
  localparam logic [SW-1:0]   DEPTH_W   = SW'(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(INST_BYTES);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
    logic            err;
  } q_entry_t;

  fetch_state_e    state_r;
  logic [XLEN-1:0] fetch_pc_r;
  logic [XLEN-1:0] resp_pc_r;
  logic [OW-1:0]   outst_r;
  logic [OW-1:0]   drop_r;
  logic [OW-1:0]   outst_nxt_s;
  logic [CW-1:0]   count_s;
  logic [SW-1:0]   credit_s;
  logic            req_fire_s;
  logic            resp_fire_s;
  logic            misalign_s;
  logic            push_s;
  logic            pop_s;
  logic            full_s;
  q_entry_t        push_entry_s;
  q_entry_t        head_s;

  // issue decision, handshakes and what (if anything) enters the queue
  always_comb begin
    credit_s           = SW'(outst_r) + SW'(count_s);
    bus.imem_req_valid = reset && (state_r == RUN) && !redirect_valid
                         && (outst_r < OUTST_MAX) && (credit_s < DEPTH_W);
    req_fire_s         = bus.imem_req_valid && bus.imem_req_ready;
    // a response with nothing outstanding is stray and ignored
    resp_fire_s        = bus.imem_resp_valid && (outst_r != '0);
    outst_nxt_s        = outst_r + OW'(req_fire_s) - OW'(resp_fire_s);
    misalign_s         = redirect_valid && pc_misaligned(redirect_pc[1:0]);
    pop_s              = bus.inst_valid && bus.inst_ready;
    push_s             = 1'b0;
    push_entry_s       = '0;
    if (redirect_valid) begin
      push_s            = misalign_s;
      push_entry_s.pc   = redirect_pc;
      push_entry_s.inst = '0;
      push_entry_s.err  = 1'b1;
    end else begin
      push_s            = resp_fire_s && (drop_r == '0) && (state_r == RUN);
      push_entry_s.pc   = resp_pc_r;
      push_entry_s.inst = bus.imem_resp_data;
      push_entry_s.err  = bus.imem_resp_err;
    end
  end

  // PC trackers, outstanding/drop counters and fetch state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= RUN;
      fetch_pc_r <= RESET_PC;
      resp_pc_r  <= RESET_PC;
      outst_r    <= '0;
      drop_r     <= '0;
    end else if (redirect_valid) begin
      fetch_pc_r <= redirect_pc;
      resp_pc_r  <= redirect_pc;
      outst_r    <= outst_nxt_s;
      drop_r     <= outst_nxt_s;
      state_r    <= misalign_s ? FAULT : RUN;
    end else begin
      outst_r <= outst_nxt_s;
      if (req_fire_s) begin
        fetch_pc_r <= fetch_pc_r + PC_STEP;
      end
      if (resp_fire_s && (drop_r != '0)) begin
        drop_r <= drop_r - OW'(1);
      end else if (push_s) begin
        resp_pc_r <= resp_pc_r + PC_STEP;
        // a faulting fetch stops issue and discards everything still in flight
        if (bus.imem_resp_err) begin
          state_r <= FAULT;
          drop_r  <= outst_nxt_s;
        end
      end
    end
  end

  ifu_inst_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (q_entry_t)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (push_s),
    .push_data  (push_entry_s),
    .pop        (pop_s),
    .head       (head_s),
    .head_valid (bus.inst_valid),
    .full       (full_s),
    .count      (count_s)
  );

  ifu_fetch_queue_chk #(
    .OW (OW)
  ) u_chk (
    .clk        (clk),
    .reset      (reset),
    .resp_valid (bus.imem_resp_valid),
    .outst      (outst_r),
    .push       (push_s),
    .full       (full_s),
    .pop        (pop_s),
    .flush      (redirect_valid)
  );

  assign bus.imem_req_addr = fetch_pc_r;
  assign bus.inst_pc       = head_s.pc;
  assign bus.inst_data     = head_s.inst;
  assign bus.inst_err      = head_s.err;
  assign busy              = (outst_r != '0) || (count_s != '0);

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Directed self-checking bench for ifu_fetch_queue with an in-order memory model.
`timescale 1ns/1ps
module tb_ifu_fetch_queue;
  import ifu_pkg::*;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        busy;

  int          n_chk;
  int          n_fail;
  logic        mem_hold;
  logic [63:0] err_addr;
  logic [63:0] mem_q    [$];
  logic [63:0] req_log  [$];
  logic [63:0] pop_pc   [$];
  logic [31:0] pop_data [$];
  logic        pop_err  [$];

  ifu_fetch_queue_if #(.XLEN(64), .ILEN(32)) bus ();

  ifu_fetch_queue #(
    .XLEN(64), .ILEN(32), .DEPTH(4), .MAX_OUTST(2), .RESET_PC(RST_PC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [63:0] a);
    return {a[31:2], 2'b11};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // one cycle: drive the memory response, log handshakes, advance to next negedge
  task automatic step();
    logic [63:0] a;
    if (!mem_hold && (mem_q.size() > 0)) begin
      a = mem_q.pop_front();
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = mem_data(a);
      bus.imem_resp_err   = (a == err_addr);
    end else begin
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = 32'h0;
      bus.imem_resp_err   = 1'b0;
    end
    #1;
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      mem_q.push_back(bus.imem_req_addr);
      req_log.push_back(bus.imem_req_addr);
    end
    if (bus.inst_valid && bus.inst_ready) begin
      pop_pc.push_back(bus.inst_pc);
      pop_data.push_back(bus.inst_data);
      pop_err.push_back(bus.inst_err);
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, 64'(bus.imem_req_valid), 64'd0);
    check({tag, "_req_addr"},  bus.imem_req_addr,       RST_PC);
    check({tag, "_inst_valid"},64'(bus.inst_valid),     64'd0);
    check({tag, "_inst_pc"},   bus.inst_pc,             64'd0);
    check({tag, "_inst_data"}, 64'(bus.inst_data),      64'd0);
    check({tag, "_inst_err"},  64'(bus.inst_err),       64'd0);
    check({tag, "_busy"},      64'(busy),               64'd0);
  endtask

  task automatic do_reset(input string tag);
    reset               = 1'b0;
    redirect_valid      = 1'b0;
    redirect_pc         = 64'h0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'h0;
    bus.imem_resp_err   = 1'b0;
    bus.imem_req_ready  = 1'b1;
    bus.inst_ready      = 1'b1;
    mem_hold            = 1'b0;
    err_addr            = '1;
    mem_q.delete();
    req_log.delete();
    pop_pc.delete();
    pop_data.delete();
    pop_err.delete();
    repeat (2) @(negedge clk);
    check_reset_outputs(tag);
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;

    // streaming fetch at one request per cycle
    do_reset("rst1");
    repeat (10) step();
    check("t1_req_count", 64'(req_log.size()), 64'd10);
    check("t1_req_last",  req_log[9], 64'h8000_0024);
    check("t1_pop_count", 64'(pop_pc.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t1_pc%0d", i), pop_pc[i], RST_PC + 64'(4 * i));
      check($sformatf("t1_err%0d", i), 64'(pop_err[i]), 64'd0);
    end
    check("t1_data3", 64'(pop_data[3]), 64'h8000_000F);

    // stalled decode: credit limits issue to the queue depth
    do_reset("rst2");
    bus.inst_ready = 1'b0;
    repeat (8) step();
    check("t2_req_count", 64'(req_log.size()), 64'd4);
    check("t2_req_last",  req_log[3], 64'h8000_000C);
    check("t2_inst_valid",64'(bus.inst_valid), 64'd1);
    check("t2_inst_pc",   bus.inst_pc, RST_PC);
    check("t2_busy",      64'(busy), 64'd1);
    bus.inst_ready = 1'b1;
    step();
    check("t2_pop_count", 64'(pop_pc.size()), 64'd1);
    check("t2_no_fifth",  64'(req_log.size()), 64'd4);
    bus.inst_ready = 1'b0;
    step();
    check("t2_fifth_cnt", 64'(req_log.size()), 64'd5);
    check("t2_fifth_addr",req_log[4], 64'h8000_0010);
    check("t2_head_pc",   bus.inst_pc, 64'h8000_0004);

    // redirect with two requests in flight
    do_reset("rst3");
    mem_hold = 1'b1;
    repeat (3) step();
    check("t3_inflight",  64'(req_log.size()), 64'd2);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0100;
    mem_hold       = 1'b0;
    step();
    redirect_valid = 1'b0;
    check("t3_flushed",   64'(bus.inst_valid), 64'd0);
    repeat (5) step();
    check("t3_req_after", req_log[2], 64'h8000_0100);
    check("t3_pop_count", 64'(pop_pc.size()), 64'd3);
    check("t3_pop_pc",    pop_pc[0], 64'h8000_0100);
    check("t3_pop_data",  64'(pop_data[0]), 64'h8000_0103);

    // fetch fault stops issue until a redirect
    do_reset("rst4");
    err_addr = RST_PC + 64'd8;
    repeat (8) step();
    check("t4_pop_count", 64'(pop_pc.size()), 64'd3);
    check("t4_err_pc",    pop_pc[2], 64'h8000_0008);
    check("t4_err_flag",  64'(pop_err[2]), 64'd1);
    check("t4_prev_err",  64'(pop_err[1]), 64'd0);
    check("t4_req_count", 64'(req_log.size()), 64'd4);
    check("t4_req_valid", 64'(bus.imem_req_valid), 64'd0);
    check("t4_busy",      64'(busy), 64'd0);
    err_addr       = '1;
    redirect_valid = 1'b1;
    redirect_pc    = RST_PC;
    step();
    redirect_valid = 1'b0;
    repeat (3) step();
    check("t4_resume_req",64'(req_log[4]), RST_PC);
    check("t4_resume_cnt",64'(pop_pc.size()), 64'd4);
    check("t4_resume_pc", pop_pc[3], RST_PC);
    check("t4_resume_err",64'(pop_err[3]), 64'd0);

    // misaligned redirect produces a single faulting entry and no request
    do_reset("rst5");
    bus.inst_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0102;
    step();
    redirect_valid = 1'b0;
    repeat (4) step();
    check("t5_no_req",    64'(req_log.size()), 64'd0);
    check("t5_valid",     64'(bus.inst_valid), 64'd1);
    check("t5_pc",        bus.inst_pc, 64'h8000_0102);
    check("t5_err",       64'(bus.inst_err), 64'd1);
    check("t5_data",      64'(bus.inst_data), 64'd0);
    bus.inst_ready = 1'b1;
    step();
    check("t5_pop_count", 64'(pop_pc.size()), 64'd1);
    check("t5_empty",     64'(bus.inst_valid), 64'd0);
    check("t5_still_none",64'(req_log.size()), 64'd0);

    // asynchronous reset mid-operation, stray responses while in reset
    do_reset("rst6");
    bus.inst_ready = 1'b0;
    repeat (2) step();
    mem_hold = 1'b1;
    repeat (2) step();
    check("t6_pre_busy",  64'(busy), 64'd1);
    check("t6_pre_valid", 64'(bus.inst_valid), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    bus.imem_resp_valid = 1'b0;
    do_reset("rst6b");
    repeat (4) step();
    check("t6_first_req", req_log[0], RST_PC);
    check("t6_pop_count", 64'(pop_pc.size()), 64'd2);
    check("t6_pop_pc",    pop_pc[0], RST_PC);
    check("t6_pop_data",  64'(pop_data[0]), 64'(mem_data(RST_PC)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
